// File: rtl/game_pkg.sv
// Shared definitions for the LED sequence game: FSM states, defaults and LFSR step.
package game_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned SYM_W = 2;
  localparam int unsigned LED_W = 1 << SYM_W;
  localparam int unsigned CNT_W = 5;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam int unsigned DEFAULT_MAX_LEN = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHOW,
    GAP,
    DONE
  } state_t;

  // Fibonacci step, taps x^16+x^14+x^13+x^11+1, shifting left into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/slow_tick_sync.sv
// Two-flop synchronizer for the slow square wave plus a both-edge tick detector.
module slow_tick_sync (
  input  logic cin,
  input  logic rst,
  input  logic slow_in,
  output logic tick
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 ^ s3;

endmodule

// File: rtl/slow_tick_sequencer.sv
// Plays a SEED-determined LFSR symbol sequence on one-hot LEDs, one step per slow tick.
module slow_tick_sequencer
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED,
  parameter int unsigned       MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic             cin,
  input  logic             rst,
  input  logic             slow_in,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [LED_W-1:0] led,
  output logic [SYM_W-1:0] sym,
  output logic             sym_valid,
  output logic             busy,
  output logic             done
);

  logic tick;

  slow_tick_sync u_sync (
    .cin    (cin),
    .rst    (rst),
    .slow_in(slow_in),
    .tick   (tick)
  );

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   eff_len;
  logic [LED_W-1:0]   led_d;
  logic [SYM_W-1:0]   sym_d;
  logic               sym_valid_d;
  logic               busy_d;
  logic               done_d;

  // Clamp the requested length into 1..MAX_LEN.
  always_comb begin
    if (len == '0) begin
      eff_len = CNT_W'(1);
    end else if (32'(len) > MAX_LEN) begin
      eff_len = CNT_W'(MAX_LEN);
    end else begin
      eff_len = len;
    end
  end

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      cnt_q     <= '0;
      len_q     <= '0;
      led       <= '0;
      sym       <= '0;
      sym_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      led       <= led_d;
      sym       <= sym_d;
      sym_valid <= sym_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    led_d       = led;
    sym_d       = sym;
    sym_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          len_d   = eff_len;
          lfsr_d  = SEED;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (tick) begin
          state_d     = SHOW;
          sym_d       = lfsr_q[SYM_W-1:0];
          led_d       = LED_W'(1) << lfsr_q[SYM_W-1:0];
          sym_valid_d = 1'b1;
        end
      end
      SHOW: begin
        if (tick) begin
          state_d = GAP;
          led_d   = '0;
          lfsr_d  = lfsr_next(lfsr_q);
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt_q == len_q) begin
            state_d = DONE;
          end else begin
            state_d     = SHOW;
            sym_d       = lfsr_q[SYM_W-1:0];
            led_d       = LED_W'(1) << lfsr_q[SYM_W-1:0];
            sym_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_slow_tick_sequencer.sv
// Directed bench for slow_tick_sequencer: reset, playback, clamping, start/reset during playback.
module tb_slow_tick_sequencer;
  import game_pkg::*;

  logic       cin = 1'b0;
  logic       rst;
  logic       slow_in;
  logic       start;
  logic [4:0] len;
  logic [3:0] led;
  logic [1:0] sym;
  logic       sym_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int passes = 0;
  int sv_total = 0;
  int done_total = 0;
  logic [1:0] sym_log [0:255];

  always #5 cin = ~cin;

  slow_tick_sequencer #(.SEED(16'hACE1), .MAX_LEN(16)) dut (
    .cin      (cin),
    .rst      (rst),
    .slow_in  (slow_in),
    .start    (start),
    .len      (len),
    .led      (led),
    .sym      (sym),
    .sym_valid(sym_valid),
    .busy     (busy),
    .done     (done)
  );

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge cin) begin
    if (sym_valid) begin
      if (sv_total < 256) sym_log[sv_total] = sym;
      sv_total = sv_total + 1;
    end
    if (done) done_total = done_total + 1;
  end

  function automatic logic [15:0] model_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [1:0] model_sym(input int idx);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < idx; i++) v = model_step(v);
    return v[1:0];
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge cin);
    #1;
  endtask

  task automatic slow_toggle(input int edges);
    slow_in = ~slow_in;
    cycles(edges);
  endtask

  task automatic pulse_start(input logic [4:0] l);
    len   = l;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cycles(3);
    checks++; if (led !== 4'b0000) $display("FAIL reset_led: got %b want 0000", led); else passes++;
    checks++; if (sym !== 2'b00) $display("FAIL reset_sym: got %b want 00", sym); else passes++;
    checks++; if (sym_valid !== 1'b0) $display("FAIL reset_sym_valid: got %b want 0", sym_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_basic;
    int sv0, d0;
    sv0 = sv_total;
    d0  = done_total;
    pulse_start(5'd2);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_arm: got %b want 1", busy); else passes++;
    slow_toggle(2);
    checks++; if (led !== 4'b0000) $display("FAIL basic_edge2_led: got %b want 0000", led); else passes++;
    cycles(1);
    checks++; if (led !== 4'b0010) $display("FAIL basic_tick1_led: got %b want 0010", led); else passes++;
    checks++; if (sym !== 2'b01) $display("FAIL basic_tick1_sym: got %b want 01", sym); else passes++;
    checks++; if (sym_valid !== 1'b1) $display("FAIL basic_tick1_valid: got %b want 1", sym_valid); else passes++;
    cycles(1);
    checks++; if (sym_valid !== 1'b0) $display("FAIL basic_valid_pulse: got %b want 0", sym_valid); else passes++;
    slow_toggle(3);
    checks++; if (led !== 4'b0000) $display("FAIL basic_tick2_led: got %b want 0000", led); else passes++;
    checks++; if (sym !== 2'b01) $display("FAIL basic_tick2_sym_hold: got %b want 01", sym); else passes++;
    slow_toggle(3);
    checks++; if (led !== 4'b1000) $display("FAIL basic_tick3_led: got %b want 1000", led); else passes++;
    checks++; if (sym !== 2'b11) $display("FAIL basic_tick3_sym: got %b want 11", sym); else passes++;
    slow_toggle(3);
    checks++; if (led !== 4'b0000) $display("FAIL basic_tick4_led: got %b want 0000", led); else passes++;
    slow_toggle(3);
    checks++; if (done !== 1'b1) $display("FAIL basic_tick5_done: got %b want 1", done); else passes++;
    cycles(1);
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else passes++;
    checks++; if (sv_total - sv0 !== 2) $display("FAIL basic_valid_count: got %0d want 2", sv_total - sv0); else passes++;
    checks++; if (done_total - d0 !== 1) $display("FAIL basic_done_count: got %0d want 1", done_total - d0); else passes++;
  endtask

  task automatic test_len0;
    int sv0;
    sv0 = sv_total;
    pulse_start(5'd0);
    slow_toggle(3);
    checks++; if (led !== 4'b0010) $display("FAIL len0_led: got %b want 0010", led); else passes++;
    slow_toggle(3);
    slow_toggle(3);
    checks++; if (done !== 1'b1) $display("FAIL len0_done: got %b want 1", done); else passes++;
    cycles(1);
    checks++; if (sv_total - sv0 !== 1) $display("FAIL len0_valid_count: got %0d want 1", sv_total - sv0); else passes++;
  endtask

  task automatic test_len20;
    int sv0;
    sv0 = sv_total;
    pulse_start(5'd20);
    for (int i = 0; i < 33; i++) slow_toggle(3);
    checks++; if (done !== 1'b1) $display("FAIL len20_done: got %b want 1", done); else passes++;
    cycles(1);
    checks++; if (busy !== 1'b0) $display("FAIL len20_busy_end: got %b want 0", busy); else passes++;
    checks++; if (sv_total - sv0 !== 16) $display("FAIL len20_valid_count: got %0d want 16", sv_total - sv0); else passes++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sym_log[sv0 + i] !== model_sym(i))
        $display("FAIL len20_sym%0d: got %b want %b", i, sym_log[sv0 + i], model_sym(i));
      else passes++;
    end
  endtask

  task automatic test_start_ignored;
    int sv0, d0;
    sv0 = sv_total;
    d0  = done_total;
    pulse_start(5'd3);
    slow_toggle(3);
    pulse_start(5'd1);
    checks++; if (led !== 4'b0010) $display("FAIL ign_led_hold: got %b want 0010", led); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", busy); else passes++;
    for (int i = 0; i < 6; i++) slow_toggle(3);
    checks++; if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done); else passes++;
    cycles(1);
    checks++; if (sv_total - sv0 !== 3) $display("FAIL ign_valid_count: got %0d want 3", sv_total - sv0); else passes++;
    checks++; if (done_total - d0 !== 1) $display("FAIL ign_done_count: got %0d want 1", done_total - d0); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sym_log[sv0 + i] !== model_sym(i))
        $display("FAIL ign_sym%0d: got %b want %b", i, sym_log[sv0 + i], model_sym(i));
      else passes++;
    end
  endtask

  task automatic test_rst_mid;
    int d0, sv0;
    d0 = done_total;
    pulse_start(5'd4);
    slow_toggle(3);
    checks++; if (led !== 4'b0010) $display("FAIL rst_pre_led: got %b want 0010", led); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (led !== 4'b0000) $display("FAIL rst_async_led: got %b want 0000", led); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else passes++;
    cycles(2);
    rst = 1'b0;
    cycles(6);
    slow_toggle(3);
    checks++; if (busy !== 1'b0) $display("FAIL rst_no_resume_busy: got %b want 0", busy); else passes++;
    checks++; if (led !== 4'b0000) $display("FAIL rst_no_resume_led: got %b want 0000", led); else passes++;
    checks++; if (done_total - d0 !== 0) $display("FAIL rst_no_done: got %0d want 0", done_total - d0); else passes++;
    sv0 = sv_total;
    pulse_start(5'd1);
    slow_toggle(3);
    checks++; if (sym !== 2'b01) $display("FAIL rst_replay_sym: got %b want 01", sym); else passes++;
    checks++; if (led !== 4'b0010) $display("FAIL rst_replay_led: got %b want 0010", led); else passes++;
    slow_toggle(3);
    slow_toggle(3);
    checks++; if (done !== 1'b1) $display("FAIL rst_replay_done: got %b want 1", done); else passes++;
    cycles(1);
    checks++; if (sv_total - sv0 !== 1) $display("FAIL rst_replay_count: got %0d want 1", sv_total - sv0); else passes++;
  endtask

  task automatic test_hold;
    int bad;
    bad = 0;
    pulse_start(5'd1);
    for (int i = 0; i < 1000; i++) begin
      cycles(1);
      if (led !== 4'b0000 || sym_valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL hold_arm: got %0d bad cycles want 0", bad); else passes++;
    slow_toggle(3);
    checks++; if (led !== 4'b0010) $display("FAIL hold_release_led: got %b want 0010", led); else passes++;
    slow_toggle(3);
    slow_toggle(3);
    checks++; if (done !== 1'b1) $display("FAIL hold_done: got %b want 1", done); else passes++;
    cycles(1);
  endtask

  initial begin
    rst     = 1'b1;
    slow_in = 1'b0;
    start   = 1'b0;
    len     = 5'd0;
    cycles(2);
    test_reset;
    test_basic;
    test_len0;
    test_len20;
    test_start_ignored;
    test_rst_mid;
    test_hold;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/slow_tick_sequencer.md
SLOW_TICK_SEQUENCER -- requirements
Module: slow_tick_sequencer

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, meaning LFSR value loaded at reset and on every accepted start.
REQ-002 SHALL have parameter MAX_LEN, default 16, meaning the longest playable sequence.
REQ-003 SHALL have port cin, input, 1, system clock (50 MHz); all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port slow_in, input, 1, slow square wave from the clock divider; each level change is one tick; asynchronous to cin.
REQ-006 SHALL have port start, input, 1, request to play a sequence; sampled every cin cycle.
REQ-007 SHALL have port len, input, 5, requested sequence length.
REQ-008 SHALL have port led, output, 4, one-hot LED drive of the shown symbol; 0 when nothing is shown.
REQ-009 SHALL have port sym, output, 2, binary index of the shown symbol.
REQ-010 SHALL have port sym_valid, output, 1, one-cycle pulse when a new symbol appears.
REQ-011 SHALL have port busy, output, 1, high outside IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when playback completes.

Function
REQ-013 SHALL pass slow_in through two flops (s1, s2), keep a third flop s3 <= s2, and drive internal tick = s2 XOR s3; both slow_in edges count as ticks.
REQ-014 SHALL implement a 16-bit Fibonacci LFSR shifting left, feedback = bit15^bit13^bit12^bit10 into bit0 (x^16+x^14+x^13+x^11+1).
REQ-015 SHALL use FSM states IDLE, ARM, SHOW, GAP, DONE.
REQ-016 In IDLE, start=1 SHALL go to ARM, latch the effective length, reload LFSR with SEED, and clear the element counter.
REQ-017 Effective length SHALL be 1 when len=0, MAX_LEN when len>MAX_LEN, else len.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 ARM + tick SHALL go to SHOW, registering sym = lfsr[1:0], led = one-hot of lfsr[1:0], and pulsing sym_valid for exactly the first SHOW cycle.
REQ-020 SHOW + tick SHALL go to GAP, driving led=0, advancing the LFSR once, and incrementing the counter.
REQ-021 GAP + tick SHALL go to DONE if counter equals the effective length, else to SHOW (REQ-019 actions).
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 Without a tick the state SHALL hold; sym SHALL keep its last value outside SHOW.
REQ-024 Outputs SHALL change on the 3rd cin rising edge after a slow_in change when it meets setup time (2 sync flops + 1 state register).
REQ-025 start arriving in the same cycle as a tick while in IDLE SHALL enter ARM; that tick SHALL NOT advance ARM.
REQ-026 The counter SHALL be 5 bits wide and never wrap; the sequence is fully determined by SEED, so a checker can regenerate it.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, lfsr=SEED, counter=0, s1/s2/s3=0, led=0, sym=0, sym_valid=0, busy=0, done=0.
REQ-028 rst during ARM, SHOW or GAP SHALL abort playback with no done pulse; after release only a new start begins a sequence.

Structure
REQ-029 SHALL place the FSM state enum, the default SEED, MAX_LEN and the symbol width (2) in shared package game_pkg, which the future input checker also uses.
REQ-030 SHALL implement the synchronizer and edge detector as sub-module slow_tick_sync (cin, rst, slow_in -> tick).

Verification
REQ-031 Reset, start=1 for 1 cycle with len=2, toggle slow_in -> after 1st tick led=4'b0010, sym=2'b01, sym_valid pulse; after 2nd led=0; after 3rd led=4'b1000, sym=2'b11; after 5th done pulse, busy=0.
REQ-032 len=0 -> exactly one SHOW (led=4'b0010); len=20 -> exactly 16 sym_valid pulses, then done.
REQ-033 start pulsed during SHOW -> ignored; pulse count and symbols match the uninterrupted run.
REQ-034 rst asserted mid-SHOW -> led=0 and busy=0 in the same cycle, no done; a new start replays from symbol 2'b01.
REQ-035 slow_in held constant for 1000 cycles in ARM -> state, led and sym_valid unchanged.
REQ-036 Single slow_in change -> exactly one state advance, output change on the 3rd cin edge.
